// File: rtl/gray_pkg.sv
// -----------------------------------------------------------------------------
// gray_pkg
//   Shared types, limits and reference helpers for the Gray<->binary pipeline.
//   - gray_mode_e : per-word conversion direction (GM_G2B = 0, GM_B2G = 1)
//   - MAX_WIDTH / MAX_STAGES : upper bounds of the WIDTH / STAGES parameters
//   - gray2bin / bin2gray : width-generic helpers operating on the low w bits
//     of a MAX_WIDTH word (upper bits of the result are zero).
// -----------------------------------------------------------------------------
package gray_pkg;

  typedef enum logic {
    GM_G2B = 1'b0,
    GM_B2G = 1'b1
  } gray_mode_e;

  localparam int MAX_WIDTH  = 32;
  localparam int MAX_STAGES = 4;

  // Running XOR from the MSB down: each binary bit is the parity of all
  // Gray bits at or above it.
  function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] g,
                                                    input int w);
    logic [MAX_WIDTH-1:0] b;
    logic                 acc;
    b   = '0;
    acc = 1'b0;
    for (int i = MAX_WIDTH - 1; i >= 0; i--) begin
      if (i < w) begin
        acc  = acc ^ g[i];
        b[i] = acc;
      end
    end
    return b;
  endfunction

  function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] b,
                                                    input int w);
    logic [MAX_WIDTH-1:0] mask;
    mask = (w >= MAX_WIDTH) ? '1 : ((MAX_WIDTH'(1) << w) - MAX_WIDTH'(1));
    return (b ^ (b >> 1)) & mask;
  endfunction

endpackage

// File: rtl/gray_conv_core.sv
// -----------------------------------------------------------------------------
// gray_conv_core
//   Purely combinational WIDTH-bit converter.
//   Ports:
//     data_i [WIDTH] : word to convert
//     mode_i         : GM_G2B -> Gray to binary, GM_B2G -> binary to Gray
//     data_o [WIDTH] : converted word
// -----------------------------------------------------------------------------
module gray_conv_core
  import gray_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data_i,
  input  gray_mode_e       mode_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] g2b;
  logic [WIDTH-1:0] b2g;
  logic             acc;

  // b[W-1] = g[W-1]; b[i] = b[i+1] ^ g[i], expressed as a running parity.
  always_comb begin
    acc = 1'b0;
    g2b = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      acc    = acc ^ data_i[i];
      g2b[i] = acc;
    end
  end

  assign b2g    = data_i ^ (data_i >> 1);
  assign data_o = (mode_i == GM_B2G) ? b2g : g2b;

endmodule

// File: rtl/gray_bin_pipe.sv
// -----------------------------------------------------------------------------
// gray_bin_pipe
//   Streaming Gray<->binary converter with a STAGES-deep pipeline and
//   valid/ready handshakes on both sides.
//
//   Handshake: a word moves on a side when valid & ready are both high at a
//   rising edge. The whole pipeline advances when (!out_valid | out_ready);
//   in_ready equals that advance term, so every stage (bubbles included)
//   holds while the output is stalled and the output word stays stable.
//
//   Parameters: WIDTH (2..32), STAGES (1..4).
//   Ports:
//     clk, rst_n          : clock, asynchronous active-low reset
//     in_valid/in_ready   : input handshake
//     in_data, in_mode    : word and direction (0 Gray->bin, 1 bin->Gray)
//     out_valid/out_ready : output handshake
//     out_data, out_mode  : converted word and the direction it used
//     adj_err             : adjacency flag aligned with out_data
//
//   Optional feature macro GRAY_ADJ_CHECK_EN: when defined, each mode=0 word
//   is compared to the previous accepted mode=0 word and adj_err flags a
//   Hamming distance other than 1. When undefined, adj_err is constant 0.
// -----------------------------------------------------------------------------
module gray_bin_pipe
  import gray_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_mode,
  output logic             adj_err
);

  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] mode_q;
  logic [STAGES-1:0] err_q;
  logic [WIDTH-1:0]  data_q [STAGES];

  logic              advance;
  logic              accept;
  logic [WIDTH-1:0]  conv_d;
  logic              err_d;

  assign advance = !vld_q[STAGES-1] || out_ready;
  assign accept  = in_valid && advance;

  gray_conv_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .data_i (in_data),
    .mode_i (gray_mode_e'(in_mode)),
    .data_o (conv_d)
  );

`ifdef GRAY_ADJ_CHECK_EN
  logic [WIDTH-1:0] hist_q, hist_d;
  logic             hist_vld_q, hist_vld_d;

  // Only accepted Gray->bin words take part; the first one after reset has
  // no history and therefore never flags.
  always_comb begin
    hist_d     = hist_q;
    hist_vld_d = hist_vld_q;
    err_d      = 1'b0;
    if (accept && (in_mode == GM_G2B)) begin
      err_d      = hist_vld_q && ($countones(in_data ^ hist_q) != 1);
      hist_d     = in_data;
      hist_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q     <= '0;
      hist_vld_q <= 1'b0;
    end else begin
      hist_q     <= hist_d;
      hist_vld_q <= hist_vld_d;
    end
  end
`else
  assign err_d = 1'b0;
`endif

  // Stage 0 captures the converted word; later stages are pure delay.
  // A cycle without in_valid loads a bubble (valid=0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      mode_q <= '0;
      err_q  <= '0;
      for (int s = 0; s < STAGES; s++) begin
        data_q[s] <= '0;
      end
    end else if (advance) begin
      vld_q[0]  <= in_valid;
      data_q[0] <= conv_d;
      mode_q[0] <= in_mode;
      err_q[0]  <= err_d;
      for (int s = 1; s < STAGES; s++) begin
        vld_q[s]  <= vld_q[s-1];
        data_q[s] <= data_q[s-1];
        mode_q[s] <= mode_q[s-1];
        err_q[s]  <= err_q[s-1];
      end
    end
  end

  assign in_ready  = advance;
  assign out_valid = vld_q[STAGES-1];
  assign out_data  = data_q[STAGES-1];
  assign out_mode  = mode_q[STAGES-1];
  assign adj_err   = err_q[STAGES-1];

endmodule

// File: tb/tb_gray_bin_pipe.sv
module tb_gray_bin_pipe;

  localparam int W = 4;
  localparam int S = 2;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_mode;
  logic         adj_err;

  always #5 clk = ~clk;

  gray_bin_pipe #(
    .WIDTH  (W),
    .STAGES (S)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_mode  (out_mode),
    .adj_err   (adj_err)
  );

  // ---------------- bookkeeping ----------------
  typedef struct {
    logic [W-1:0] data;
    logic         mode;
    logic         err;
    int           cyc;
  } exp_t;

  exp_t         exp_q[$];
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           last_stall = -1;
  int           n_out = 0;
  logic [W-1:0] drv_exp;
  logic         hold_vld = 1'b0;
  logic [W-1:0] hold_data;
  logic         hold_mode;
`ifdef GRAY_ADJ_CHECK_EN
  logic [W-1:0] hist;
  logic         hist_vld = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model, written independently of the design's structure.
  function automatic logic [W-1:0] ref_g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    for (int i = 0; i < W; i++) b[i] = ^(g >> i);
    return b;
  endfunction

  function automatic logic [W-1:0] ref_b2g(input logic [W-1:0] b);
    logic [W-1:0] g;
    for (int i = 0; i < W; i++) g[i] = (i == W - 1) ? b[i] : (b[i] ^ b[i+1]);
    return g;
  endfunction

  function automatic logic [W-1:0] ref_conv(input logic mode, input logic [W-1:0] d);
    return mode ? ref_b2g(d) : ref_g2b(d);
  endfunction

  // ---------------- monitor / scoreboard (mid-cycle sampling) ----------------
  always @(negedge clk) begin
    exp_t e;
    logic e_err;
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      hold_vld = 1'b0;
`ifdef GRAY_ADJ_CHECK_EN
      hist_vld = 1'b0;
`endif
    end else begin
      if (hold_vld) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, hold_data);
        check("hold_mode", out_mode, hold_mode);
      end
      hold_vld = 1'b0;
      if (out_valid && !out_ready) begin
        check("stall_in_ready", in_ready, 0);
        last_stall = cyc;
        hold_vld   = 1'b1;
        hold_data  = out_data;
        hold_mode  = out_mode;
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_out: got data %0h with empty expected queue (cycle %0d)",
                   out_data, cyc);
        end else begin
          e = exp_q.pop_front();
          check("out_data", out_data, e.data);
          check("out_mode", out_mode, e.mode);
          check("adj_err", adj_err, e.err);
          if (last_stall <= e.cyc) check("latency", cyc - e.cyc, S);
        end
      end
      if (in_valid && in_ready) begin
        e_err = 1'b0;
`ifdef GRAY_ADJ_CHECK_EN
        if (in_mode == 1'b0) begin
          if (hist_vld && ($countones(in_data ^ hist) != 1)) e_err = 1'b1;
          hist     = in_data;
          hist_vld = 1'b1;
        end
`endif
        e.data = drv_exp;
        e.mode = in_mode;
        e.err  = e_err;
        e.cyc  = cyc;
        exp_q.push_back(e);
      end
    end
  end

  // ---------------- driver tasks (called at posedge + 1) ----------------
  task automatic send(input logic mode, input logic [W-1:0] d, input logic [W-1:0] exp_d);
    int n;
    in_valid = 1'b1;
    in_mode  = mode;
    in_data  = d;
    drv_exp  = exp_d;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: in_ready stuck at %0b, expected 1 within 100 cycles", in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_data  = W'($urandom);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      n++;
      @(posedge clk);
    end
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d words still pending, expected 0", exp_q.size());
    end
    idle(2);
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    logic         mode;
    logic [W-1:0] din;
    logic [W-1:0] dout;
  } vec_t;

  vec_t tbl[8];
  logic rnd_done;
  int   out_base;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mode   = 1'b0;
    out_ready = 1'b1;
    rnd_done  = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    rst_n = 1'b1;
    #1;
    check("rst_out_valid_rel", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_mode", out_mode, 0);
    check("rst_adj_err", adj_err, 0);
    check("rst_in_ready", in_ready, 1);
    idle(1);

    // Known vectors
    tbl[0] = '{1'b0, 4'b1011, 4'b1101};
    tbl[1] = '{1'b1, 4'b0110, 4'b0101};
    tbl[2] = '{1'b0, 4'b1000, 4'b1111};
    tbl[3] = '{1'b0, 4'b0000, 4'b0000};
    tbl[4] = '{1'b1, 4'b1111, 4'b1000};
    tbl[5] = '{1'b0, 4'b0111, 4'b0101};
    tbl[6] = '{1'b1, 4'b0000, 4'b0000};
    tbl[7] = '{1'b1, 4'b1000, 4'b1100};
    for (int i = 0; i < 8; i++) send(tbl[i].mode, tbl[i].din, tbl[i].dout);
    drain();

    // Exhaustive, both directions, full rate
    for (int i = 0; i < 16; i++) send(1'b0, W'(i), ref_conv(1'b0, W'(i)));
    for (int i = 0; i < 16; i++) send(1'b1, W'(i), ref_conv(1'b1, W'(i)));
    drain();

    // Backpressure: 8 words, out_ready low for cycles 3..6
    out_base = n_out;
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          logic [W-1:0] d;
          d = W'($urandom);
          send(k[0], d, ref_conv(k[0], d));
        end
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    check("bp_word_count", n_out - out_base, 8);

    // Wrap-around and adjacency sequence
    send(1'b0, 4'b1000, 4'b1111);
    send(1'b0, 4'b0000, 4'b0000);
    send(1'b0, 4'b1000, 4'b1111);
    send(1'b0, 4'b1011, 4'b1101);
    drain();

    // Reset with two words in flight
    send(1'b0, 4'b0011, 4'b0010);
    send(1'b1, 4'b0101, 4'b0111);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    out_base = n_out;
    idle(6);
    check("no_stale_words", n_out - out_base, 0);
    send(1'b0, 4'b0110, 4'b0100);
    send(1'b0, 4'b0111, 4'b0101);
    drain();

    // Random words, random mode, random gaps, random out_ready
    fork
      begin
        for (int k = 0; k < 200; k++) begin
          logic [W-1:0] d;
          logic         m;
          d = W'($urandom);
          m = 1'($urandom_range(0, 1));
          if ($urandom_range(0, 3) == 0) idle(1);
          send(m, d, ref_conv(m, d));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    total++;
    bad++;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
